// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between instruction fetch and data accesses
// Data wins ties until a waiting fetch has been passed over STARVE_LIMIT times in a row.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [10:0] if_addr,
    output logic        if_gnt,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [2:0]  d_fn3,
    input  logic [10:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_valid,
    output logic [31:0] d_rdata,
    output logic        if_stall,
    output logic        d_stall,
    output logic        mem_read,
    output logic        mem_write,
    output logic [2:0]  fn3,
    output logic [10:0] addrs,
    output logic [31:0] data_in,
    input  logic [31:0] data_out
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, RSP_I, RSP_D} state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [CW-1:0] r_starve_cnt;
    logic [10:0]   r_addrs;
    logic [2:0]    r_fn3;
    logic [31:0]   r_data_in;
    logic [31:0]   r_if_rdata;
    logic [31:0]   r_d_rdata;
    logic          w_d_req;
    logic          w_starved;
    logic          w_if_gnt;
    logic          w_d_gnt;
    logic          w_d_is_read;

    assign w_d_req     = d_read | d_write;
    assign w_d_is_read = d_read & ~d_write;
    assign w_starved   = if_req && (r_starve_cnt == LIMIT);
    // Grants are gated by reset so nothing reaches the memory while rst is low.
    assign w_d_gnt     = rst & w_d_req & ~w_starved;
    assign w_if_gnt    = rst & if_req & ~w_d_gnt;

    assign if_gnt   = w_if_gnt;
    assign d_gnt    = w_d_gnt;
    assign if_stall = if_req & ~w_if_gnt;
    assign d_stall  = w_d_req & ~w_d_gnt;
    assign if_rdata = r_if_rdata;
    assign d_rdata  = r_d_rdata;

    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        fn3       = r_fn3;
        addrs     = r_addrs;
        data_in   = r_data_in;
        if (w_if_gnt) begin
            fn3   = 3'b010;
            addrs = if_addr;
        end else if (w_d_gnt) begin
            mem_read  = w_d_is_read;
            mem_write = d_write;
            fn3       = d_fn3;
            addrs     = d_addr;
            data_in   = d_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = IDLE;
        if (w_if_gnt) begin
            w_next_state = RSP_I;
        end else if (w_d_gnt) begin
            w_next_state = RSP_D;
        end
    end

    always_comb begin
        if_valid = (r_state == RSP_I);
        d_valid  = (r_state == RSP_D);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve_cnt <= '0;
        end else if (w_if_gnt || !if_req) begin
            r_starve_cnt <= '0;
        end else if (w_d_gnt && (r_starve_cnt != LIMIT)) begin
            r_starve_cnt <= r_starve_cnt + CW'(1);
        end
    end

    // Last driven access fields are held so idle cycles keep the memory bus quiet.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addrs    <= '0;
            r_fn3      <= '0;
            r_data_in  <= '0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else begin
            if (w_if_gnt || w_d_gnt) begin
                r_addrs   <= addrs;
                r_fn3     <= fn3;
                r_data_in <= data_in;
            end
            if (w_if_gnt) begin
                r_if_rdata <= data_out;
            end
            if (w_d_gnt && w_d_is_read) begin
                r_d_rdata <= data_out;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed bench with a per-cycle reference model for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int LIM = 3;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [10:0] if_addr;
    logic        if_gnt, if_valid;
    logic [31:0] if_rdata;
    logic        d_read, d_write;
    logic [2:0]  d_fn3;
    logic [10:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt, d_valid;
    logic [31:0] d_rdata;
    logic        if_stall, d_stall;
    logic        mem_read, mem_write;
    logic [2:0]  fn3;
    logic [10:0] addrs;
    logic [31:0] data_in;
    logic [31:0] data_out;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: pending response kind (0 none, 1 fetch, 2 data), counters, held fields.
    int          m_cnt  = 0;
    int          m_resp = 0;
    logic [31:0] m_if_rdata = 0;
    logic [31:0] m_d_rdata  = 0;
    logic [10:0] m_addrs = 0;
    logic [2:0]  m_fn3   = 0;
    logic [31:0] m_din   = 0;
    logic        e_ig = 0;
    logic        e_dg = 0;

    mem_port_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
        .d_read(d_read), .d_write(d_write), .d_fn3(d_fn3), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
        .if_stall(if_stall), .d_stall(d_stall),
        .mem_read(mem_read), .mem_write(mem_write), .fn3(fn3), .addrs(addrs),
        .data_in(data_in), .data_out(data_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // Compare process: expected outputs straight from the arbitration rules.
    initial begin
        logic        dreq, ig, dg;
        logic        x_rd, x_wr;
        logic [2:0]  x_fn3;
        logic [10:0] x_addr;
        logic [31:0] x_din;
        forever begin
            @(negedge clk);
            dreq = d_read | d_write;
            dg = rst && dreq && !(if_req && m_cnt >= LIM);
            ig = rst && if_req && !dg;
            x_rd = 1'b0; x_wr = 1'b0; x_fn3 = m_fn3; x_addr = m_addrs; x_din = m_din;
            if (ig) begin
                x_fn3 = 3'b010; x_addr = if_addr;
            end else if (dg) begin
                x_rd = d_read & ~d_write; x_wr = d_write;
                x_fn3 = d_fn3; x_addr = d_addr; x_din = d_wdata;
            end
            chk("if_gnt",    32'(if_gnt),    32'(ig));
            chk("d_gnt",     32'(d_gnt),     32'(dg));
            chk("if_stall",  32'(if_stall),  32'(if_req & ~ig));
            chk("d_stall",   32'(d_stall),   32'(dreq & ~dg));
            chk("mem_read",  32'(mem_read),  32'(x_rd));
            chk("mem_write", 32'(mem_write), 32'(x_wr));
            chk("fn3",       32'(fn3),       32'(x_fn3));
            chk("addrs",     32'(addrs),     32'(x_addr));
            chk("data_in",   data_in,        x_din);
            chk("if_valid",  32'(if_valid),  32'(m_resp == 1));
            chk("d_valid",   32'(d_valid),   32'(m_resp == 2));
            chk("if_rdata",  if_rdata,       m_if_rdata);
            chk("d_rdata",   d_rdata,        m_d_rdata);
            e_ig = ig;
            e_dg = dg;
        end
    end

    // Model update at each accept edge; reset wipes everything immediately.
    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_cnt = 0; m_resp = 0; m_if_rdata = 0; m_d_rdata = 0;
                m_addrs = 0; m_fn3 = 0; m_din = 0; e_ig = 0; e_dg = 0;
            end else begin
                m_resp = e_ig ? 1 : (e_dg ? 2 : 0);
                if (e_ig) begin
                    m_if_rdata = data_out; m_addrs = if_addr; m_fn3 = 3'b010;
                end else if (e_dg) begin
                    m_addrs = d_addr; m_fn3 = d_fn3; m_din = d_wdata;
                    if (!d_write) m_d_rdata = data_out;
                end
                if (e_ig || !if_req) m_cnt = 0;
                else if (e_dg) m_cnt = (m_cnt + 1 > LIM) ? LIM : m_cnt + 1;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in;
        if_req = 0; if_addr = 0; d_read = 0; d_write = 0; d_fn3 = 0; d_addr = 0; d_wdata = 0;
    endtask

    initial begin
        logic [4:0] got;
        rst = 0; data_out = 0;
        idle_in();
        @(negedge clk);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_addrs", 32'(addrs), 32'h0);
        tick();
        rst = 1;

        // Fetch of 0x004
        if_req = 1; if_addr = 11'h004; data_out = 32'h0000_2083;
        @(negedge clk);
        chk("lit_fetch_gnt", 32'(if_gnt), 32'h1);
        tick();
        idle_in(); data_out = 32'hffff_ffff;
        @(negedge clk);
        chk("lit_fetch_valid", 32'(if_valid), 32'h1);
        chk("lit_fetch_rdata", if_rdata, 32'h0000_2083);
        tick();

        // Load word from 0x000
        d_read = 1; d_fn3 = 3'b010; d_addr = 11'h000; data_out = 32'd17;
        @(negedge clk);
        chk("lit_load_mem_read", 32'(mem_read), 32'h1);
        chk("lit_load_addrs", 32'(addrs), 32'h0);
        tick();
        idle_in();
        @(negedge clk);
        chk("lit_load_valid", 32'(d_valid), 32'h1);
        chk("lit_load_rdata", d_rdata, 32'd17);
        tick();

        // Store word to 0x00C
        d_write = 1; d_fn3 = 3'b010; d_addr = 11'h00C; d_wdata = 32'd34; data_out = 32'd55;
        @(negedge clk);
        chk("lit_store_mem_write", 32'(mem_write), 32'h1);
        chk("lit_store_data_in", data_in, 32'd34);
        tick();
        idle_in();
        @(negedge clk);
        chk("lit_store_valid", 32'(d_valid), 32'h1);
        chk("lit_store_rdata_kept", d_rdata, 32'd17);
        chk("lit_idle_addr_hold", 32'(addrs), 32'h00C);
        tick();

        // Contention for five cycles
        if_req = 1; if_addr = 11'h008; d_read = 1; d_fn3 = 3'b010; d_addr = 11'h010;
        for (int i = 0; i < 5; i++) begin
            data_out = 32'd100 + 32'(i);
            @(negedge clk);
            got[i] = d_gnt;
            if (i < 3) chk("lit_starve_if_stall", 32'(if_stall), 32'h1);
            tick();
        end
        chk("lit_grant_order", 32'(got), 32'(5'b10111));

        // Read and write together resolve to a write
        idle_in();
        d_read = 1; d_write = 1; d_fn3 = 3'b000; d_addr = 11'h031; d_wdata = 32'hA5A5_0001;
        data_out = 32'h1111_2222;
        @(negedge clk);
        chk("lit_rw_mem_write", 32'(mem_write), 32'h1);
        chk("lit_rw_mem_read", 32'(mem_read), 32'h0);
        tick();

        // Starvation counter cleared by a gap in if_req
        idle_in();
        d_read = 1; d_fn3 = 3'b100; d_addr = 11'h040; if_addr = 11'h0C0; data_out = 32'h33;
        for (int i = 0; i < 8; i++) begin
            if_req = (i != 2);
            data_out = 32'h200 + 32'(i);
            tick();
        end
        idle_in();
        tick();

        // Reset pulse right after a fetch accept
        if_req = 1; if_addr = 11'h020; data_out = 32'hDEAD_BEEF;
        tick();
        rst = 0;
        idle_in();
        #1;
        rst = 1;
        if_req = 1; if_addr = 11'h024; data_out = 32'h0000_1234;
        @(negedge clk);
        chk("lit_rst_no_valid", 32'(if_valid), 32'h0);
        chk("lit_rst_rdata", if_rdata, 32'h0);
        chk("lit_rst_regrant", 32'(if_gnt), 32'h1);
        tick();
        idle_in();
        @(negedge clk);
        chk("lit_rst_next_rdata", if_rdata, 32'h0000_1234);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
